key_filter_multi: RTL and testbench
===================================

Name: key_filter_multi

Overview:
Parametrised multi-channel key debouncer and press classifier. It is the successor to the single-key double-edge filter. Each of N_KEYS raw push-button inputs gets:
- a 2-flop synchroniser,
- a glitch-rejecting debounce FSM on both edges,
- long-press detection and optional auto-repeat.
Sits between board buttons and the image-process control logic (mode/threshold selection), all in the single system clock domain.

Parameters:
N_KEYS, 4, number of independent key channels (1..16)
CLK_FREQ_HZ, 65_000_000, clk frequency; derives cycle counts
DEBOUNCE_MS, 20, stable time required on each edge
LONG_MS, 1000, hold time before long_pulse
REPEAT_MS, 200, auto-repeat period after long press
REPEAT_EN, 1, 1 = emit repeat_pulse while held past long press; 0 = never
ACTIVE_LOW, 1, 1 = key pressed when pin is 0; 0 = pressed when pin is 1
Derived cycle counts (integer): CYC_PER_MS = CLK_FREQ_HZ/1000; DB_CYC = CYC_PER_MS*DEBOUNCE_MS; LONG_CYC = CYC_PER_MS*LONG_MS; REP_CYC = CYC_PER_MS*REPEAT_MS. Required: DB_CYC>=2, LONG_CYC>DB_CYC, REP_CYC>=1. Counter widths = $clog2(max+1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
keyin  in  N_KEYS  raw asynchronous key pins, bit i = channel i
key_level  out  N_KEYS  debounced pressed state (1 = pressed)
press_pulse  out  N_KEYS  1-cycle pulse on debounced press
release_pulse  out  N_KEYS  1-cycle pulse on debounced release
click_pulse  out  N_KEYS  1-cycle pulse on release if long_pulse did not fire during that press
long_pulse  out  N_KEYS  1-cycle pulse when held LONG_CYC cycles
repeat_pulse  out  N_KEYS  1-cycle pulse every REP_CYC cycles after long_pulse while held

Behaviour:
- Channels are fully independent; identical logic is replicated per bit. Everything below is per channel.
- Sync: 2 flops. act = synced pin XOR ACTIVE_LOW. Sync flops reset to the inactive pin level.
- Reset (async, any time, including mid-count): FSM=IDLE, all counters 0, all outputs 0.
- All outputs are registered. Pulses last exactly 1 cycle.
- FSM states: IDLE, PRESS_CNT, HELD, REL_CNT.
  - IDLE: act=1 -> PRESS_CNT, db_cnt=0.
  - PRESS_CNT: db_cnt increments each cycle. act=0 at any point -> IDLE, no output; the glitch is rejected and the timer restarts on the next activity. db_cnt==DB_CYC-1 with act=1 -> HELD; key_level<=1, press_pulse<=1, hold_cnt=0, long_done=0.
  - HELD: hold_cnt increments, saturating at its maximum. At hold_cnt==LONG_CYC-1: long_pulse<=1, long_done=1, rep_cnt=0. After that, if REPEAT_EN, rep_cnt counts and repeat_pulse<=1 each time rep_cnt==REP_CYC-1 (rep_cnt then reloads 0). act=0 -> REL_CNT, db_cnt=0.
  - REL_CNT: hold_cnt and rep_cnt are frozen; key_level stays 1. act=1 before completion -> HELD; counters resume from their frozen values. db_cnt==DB_CYC-1 with act=0 -> IDLE; key_level<=0, release_pulse<=1, click_pulse<=!long_done.
- Latency: a clean pin edge sampled at edge k gives press_pulse/key_level rise (or release_pulse/key_level fall) registered at edge k+DB_CYC+3. This is 2 sync cycles + 1 IDLE/HELD detect cycle + DB_CYC count cycles.
- Simultaneous events: press_pulse and long_pulse never coincide (LONG_CYC>DB_CYC). A long_pulse or repeat_pulse cannot fire in REL_CNT. Different channels may pulse in the same cycle.
- No pulse is emitted from PRESS_CNT. A press shorter than DB_CYC cycles produces no output at all.

Test Plan:
Params for all tests: CLK_FREQ_HZ=10_000, DEBOUNCE_MS=1, LONG_MS=5, REPEAT_MS=2, N_KEYS=4, ACTIVE_LOW=1 (DB_CYC=10, LONG_CYC=50, REP_CYC=20).
1. Clean press: keyin[0] 1->0 at edge 100, held 30 cycles, then 0->1 -> press_pulse[0] high exactly at edge 113; release_pulse[0] and click_pulse[0] at edge 143; long_pulse never; key_level[0] high edges 113..142.
2. Bounce rejection: keyin[1] toggles low/high every 4 cycles for 40 cycles, then stays high -> all outputs on ch1 stay 0.
3. Long+repeat: keyin[2] low for 120 cycles -> long_pulse at press+50 cycles, repeat_pulse at +70 and +90; then on release, release_pulse=1, click_pulse=0. With REPEAT_EN=0, no repeat_pulse.
4. Release glitch: during HELD, pin high for 5 cycles then low again -> no release_pulse, key_level stays 1; long_pulse timing is shifted by 5 (frozen) cycles.
5. Reset mid-operation: assert rst during PRESS_CNT and again during HELD -> all outputs 0 immediately. After rst drops with the pin still held low, a fresh press_pulse comes 13 cycles later.
6. Multi-channel: ch0 and ch3 pressed on the same edge -> press_pulse=4'b1001 in one cycle; ch1/ch2 are unaffected.

Source files
------------

// File: rtl/key_filter_if.sv
// Raw key pins in, per-channel debounced level and event pulses out.
// The key filter is the slave side.
interface key_filter_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] keyin;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] click_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] repeat_pulse;

    modport master (
        output keyin,
        input  key_level, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  keyin,
        output key_level, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: per key a 2-flop synchroniser, a two-edge debounce FSM,
// and long-press / auto-repeat detection. All outputs registered.
//
// state     | meaning
// IDLE      | key released and stable, waiting for activity
// PRESS_CNT | key active, counting debounce time before accepting the press
// HELD      | press accepted, timing the hold for long press and repeat
// REL_CNT   | key inactive, counting debounce time; hold timers frozen
module key_filter_multi #(
    parameter int N_KEYS      = 4,
    parameter int CLK_FREQ_HZ = 65_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    key_filter_if.slave kf
);
    localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int DB_CYC     = CYC_PER_MS * DEBOUNCE_MS;
    localparam int LONG_CYC   = CYC_PER_MS * LONG_MS;
    localparam int REP_CYC    = CYC_PER_MS * REPEAT_MS;

    localparam int DB_W   = $clog2(DB_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int REP_W  = $clog2(REP_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);
    localparam logic              PIN_IDLE  = (ACTIVE_LOW != 0);

    if (DB_CYC < 2 || LONG_CYC <= DB_CYC || REP_CYC < 1 || N_KEYS < 1 || N_KEYS > 16) begin : g_param_check
        $error("key_filter_multi: illegal channel count or timing parameters");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } state_t;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic [1:0]        sync_q;
        logic              act;
        state_t            state_q, state_d;
        logic [DB_W-1:0]   db_q, db_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [REP_W-1:0]  rep_q, rep_d;
        logic              long_done_q, long_done_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              rel_q, rel_d;
        logic              click_q, click_d;
        logic              long_q, long_d;
        logic              rpt_q, rpt_d;

        // Sync flops reset to the idle pin level so reset never looks like a press.
        assign act = sync_q[1] ^ PIN_IDLE;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q      <= {2{PIN_IDLE}};
                state_q     <= IDLE;
                db_q        <= '0;
                hold_q      <= '0;
                rep_q       <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                rel_q       <= 1'b0;
                click_q     <= 1'b0;
                long_q      <= 1'b0;
                rpt_q       <= 1'b0;
            end else begin
                sync_q      <= {sync_q[0], kf.keyin[g]};
                state_q     <= state_d;
                db_q        <= db_d;
                hold_q      <= hold_d;
                rep_q       <= rep_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                rel_q       <= rel_d;
                click_q     <= click_d;
                long_q      <= long_d;
                rpt_q       <= rpt_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            db_d        = db_q;
            hold_d      = hold_q;
            rep_d       = rep_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            rel_d       = 1'b0;
            click_d     = 1'b0;
            long_d      = 1'b0;
            rpt_d       = 1'b0;
            case (state_q)
                IDLE: begin
                    if (act) begin
                        state_d = PRESS_CNT;
                        db_d    = '0;
                    end
                end
                PRESS_CNT: begin
                    if (!act) begin
                        state_d = IDLE;
                    end else if (db_q == DB_LAST) begin
                        state_d     = HELD;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        hold_d      = '0;
                        long_done_d = 1'b0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                HELD: begin
                    // Every HELD cycle counts, including the one that first sees release.
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                    if (!long_done_q) begin
                        if (hold_q == LONG_LAST) begin
                            long_d      = 1'b1;
                            long_done_d = 1'b1;
                            rep_d       = '0;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (rep_q == REP_LAST) begin
                            rpt_d = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                    if (!act) begin
                        state_d = REL_CNT;
                        db_d    = '0;
                    end
                end
                REL_CNT: begin
                    if (act) begin
                        state_d = HELD;
                    end else if (db_q == DB_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        click_d = !long_done_q;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign kf.key_level[g]     = level_q;
        assign kf.press_pulse[g]   = press_q;
        assign kf.release_pulse[g] = rel_q;
        assign kf.click_pulse[g]   = click_q;
        assign kf.long_pulse[g]    = long_q;
        assign kf.repeat_pulse[g]  = rpt_q;
    end
endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: directed scenarios plus random pin activity, checked against
// a run-length reference model; a second instance has auto-repeat disabled.
module tb_key_filter_multi;
    localparam int N       = 4;
    localparam int CLK_HZ  = 10_000;
    localparam int DB_MS   = 1;
    localparam int LONG_MS = 5;
    localparam int REP_MS  = 2;
    localparam bit ACT_LOW = 1'b1;
    localparam int DB      = (CLK_HZ / 1000) * DB_MS;
    localparam int LONG    = (CLK_HZ / 1000) * LONG_MS;
    localparam int REP     = (CLK_HZ / 1000) * REP_MS;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] keyin_tb = '1;

    always #5 clk = ~clk;

    key_filter_if #(.N_KEYS(N)) kf_a ();
    key_filter_if #(.N_KEYS(N)) kf_b ();
    assign kf_a.keyin = keyin_tb;
    assign kf_b.keyin = keyin_tb;

    key_filter_multi #(.N_KEYS(N), .CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_MS(DB_MS), .LONG_MS(LONG_MS),
                       .REPEAT_MS(REP_MS), .REPEAT_EN(1), .ACTIVE_LOW(1))
        dut_a (.clk(clk), .rst(rst), .kf(kf_a));
    key_filter_multi #(.N_KEYS(N), .CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_MS(DB_MS), .LONG_MS(LONG_MS),
                       .REPEAT_MS(REP_MS), .REPEAT_EN(0), .ACTIVE_LOW(1))
        dut_b (.clk(clk), .rst(rst), .kf(kf_b));

    logic [6*N-1:0] obs_a, obs_b;
    assign obs_a = {kf_a.key_level, kf_a.press_pulse, kf_a.release_pulse,
                    kf_a.click_pulse, kf_a.long_pulse, kf_a.repeat_pulse};
    assign obs_b = {kf_b.key_level, kf_b.press_pulse, kf_b.release_pulse,
                    kf_b.click_pulse, kf_b.long_pulse, kf_b.repeat_pulse};

    int n_checks;
    int n_fail;
    int cyc;

    // Reference model: a level flips once DB+1 consecutive synced samples disagree with it;
    // hold time counts cycles whose previous sample was still active.
    logic [N-1:0] m_d1, m_d2, m_pact, m_lvl, m_ldone;
    logic [N-1:0] m_prs, m_rel, m_clk, m_lng, m_rep;
    int           m_run  [N];
    int           m_hold [N];

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_pact = '0; m_lvl = '0; m_ldone = '0;
        m_prs = '0; m_rel = '0; m_clk = '0; m_lng = '0; m_rep = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_hold[i] = 0;
        end
    endtask

    task automatic model_step();
        logic a;
        m_prs = '0; m_rel = '0; m_clk = '0; m_lng = '0; m_rep = '0;
        for (int i = 0; i < N; i++) begin
            a       = m_d2[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = keyin_tb[i] ^ ACT_LOW;
            if (m_lvl[i] && m_pact[i]) begin
                m_hold[i]++;
                if (m_hold[i] == LONG) begin
                    m_lng[i]   = 1'b1;
                    m_ldone[i] = 1'b1;
                end else if (m_hold[i] > LONG && ((m_hold[i] - LONG) % REP) == 0) begin
                    m_rep[i] = 1'b1;
                end
            end
            if (a != m_lvl[i]) m_run[i]++;
            else               m_run[i] = 0;
            if (m_run[i] == DB + 1) begin
                m_run[i] = 0;
                if (!m_lvl[i]) begin
                    m_lvl[i]   = 1'b1;
                    m_prs[i]   = 1'b1;
                    m_hold[i]  = 0;
                    m_ldone[i] = 1'b0;
                end else begin
                    m_lvl[i] = 1'b0;
                    m_rel[i] = 1'b1;
                    m_clk[i] = ~m_ldone[i];
                end
            end
            m_pact[i] = a;
        end
    endtask

    function automatic logic [6*N-1:0] exp_vec(input bit rep_en);
        return {m_lvl, m_prs, m_rel, m_clk, m_lng, rep_en ? m_rep : {N{1'b0}}};
    endfunction

    // One clock: advance the model on the edge, drive new pins just after it, return at the
    // following falling edge where outputs are sampled.
    task automatic step(input logic [N-1:0] pins);
        @(posedge clk);
        cyc++;
        if (!rst) model_step();
        #1 keyin_tb = pins;
        @(negedge clk);
    endtask

    task automatic test_reset();
        keyin_tb = '1;
        rst      = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs_a !== '0 || obs_b !== '0) begin
            n_fail++;
            $display("FAIL reset_async got_a=%h got_b=%h exp=0", obs_a, obs_b);
        end
        for (int k = 0; k < 3; k++) step('1);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step('1);
            n_checks++;
            if (obs_a !== '0 || obs_b !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got_a=%h got_b=%h exp=0", cyc, obs_a, obs_b);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] got5, exp5;
        step(4'b1110);
        for (int k = 1; k <= 49; k++) begin
            step(k < 30 ? 4'b1110 : 4'b1111);
            got5 = {kf_a.key_level[0], kf_a.press_pulse[0], kf_a.release_pulse[0],
                    kf_a.click_pulse[0], kf_a.long_pulse[0]};
            exp5 = {(k >= 13 && k <= 42), (k == 13), (k == 43), (k == 43), 1'b0};
            n_checks++;
            if (got5 !== exp5) begin
                n_fail++;
                $display("FAIL clean_press_ch0 k=%0d got=%b exp=%b", k, got5, exp5);
            end
            n_checks++;
            if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL clean_press_model cyc=%0d got_a=%h got_b=%h exp_a=%h", cyc, obs_a, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] got_a6, got_b6;
        for (int k = 0; k < 70; k++) begin
            step((k < 40 && ((k / 4) % 2) == 0) ? 4'b1101 : 4'b1111);
            got_a6 = {kf_a.key_level[1], kf_a.press_pulse[1], kf_a.release_pulse[1],
                      kf_a.click_pulse[1], kf_a.long_pulse[1], kf_a.repeat_pulse[1]};
            got_b6 = {kf_b.key_level[1], kf_b.press_pulse[1], kf_b.release_pulse[1],
                      kf_b.click_pulse[1], kf_b.long_pulse[1], kf_b.repeat_pulse[1]};
            n_checks++;
            if (got_a6 !== 6'b0 || got_b6 !== 6'b0) begin
                n_fail++;
                $display("FAIL bounce_ch1 k=%0d got_a=%b got_b=%b exp=000000", k, got_a6, got_b6);
            end
            n_checks++;
            if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL bounce_model cyc=%0d got_a=%h got_b=%h exp_a=%h", cyc, obs_a, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [3:0] got4, exp4;
        logic [1:0] got_b2, exp_b2;
        step(4'b1011);
        for (int k = 1; k <= 145; k++) begin
            step(k < 120 ? 4'b1011 : 4'b1111);
            got4 = {kf_a.press_pulse[2], kf_a.long_pulse[2], kf_a.release_pulse[2], kf_a.click_pulse[2]};
            exp4 = {(k == 13), (k == 63), (k == 133), 1'b0};
            n_checks++;
            if (got4 !== exp4) begin
                n_fail++;
                $display("FAIL long_ch2 k=%0d got=%b exp=%b", k, got4, exp4);
            end
            if (k <= 110) begin
                n_checks++;
                if (kf_a.repeat_pulse[2] !== (k == 83 || k == 103)) begin
                    n_fail++;
                    $display("FAIL repeat_ch2 k=%0d got=%b exp=%b", k, kf_a.repeat_pulse[2], (k == 83 || k == 103));
                end
            end
            got_b2 = {kf_b.long_pulse[2], kf_b.repeat_pulse[2]};
            exp_b2 = {(k == 63), 1'b0};
            n_checks++;
            if (got_b2 !== exp_b2) begin
                n_fail++;
                $display("FAIL no_repeat_ch2 k=%0d got=%b exp=%b", k, got_b2, exp_b2);
            end
            n_checks++;
            if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL long_model cyc=%0d got_a=%h got_b=%h exp_a=%h", cyc, obs_a, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_release_glitch();
        logic [4:0] got5, exp5;
        step(4'b1110);
        for (int k = 1; k <= 125; k++) begin
            step(((k >= 30 && k <= 34) || k >= 100) ? 4'b1111 : 4'b1110);
            got5 = {kf_a.key_level[0], kf_a.press_pulse[0], kf_a.release_pulse[0],
                    kf_a.click_pulse[0], kf_a.long_pulse[0]};
            exp5 = {(k >= 13 && k <= 112), (k == 13), (k == 113), 1'b0, (k == 68)};
            n_checks++;
            if (got5 !== exp5) begin
                n_fail++;
                $display("FAIL rel_glitch_ch0 k=%0d got=%b exp=%b", k, got5, exp5);
            end
            n_checks++;
            if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL rel_glitch_model cyc=%0d got_a=%h got_b=%h exp_a=%h", cyc, obs_a, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            step(4'b1110);
            for (int k = 1; k <= (pass == 0 ? 7 : 0); k++) step(4'b1110);
            rst = 1'b1;
            model_reset();
            #1;
            n_checks++;
            if (obs_a !== '0 || obs_b !== '0) begin
                n_fail++;
                $display("FAIL reset_mid pass=%0d got_a=%h got_b=%h exp=0", pass, obs_a, obs_b);
            end
            for (int k = 0; k < 3; k++) step(4'b1110);
            rst = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                step(4'b1110);
                n_checks++;
                if (kf_a.press_pulse[0] !== (k == 13) || kf_a.key_level[0] !== (k >= 13)) begin
                    n_fail++;
                    $display("FAIL reset_repress pass=%0d k=%0d got_press=%b got_level=%b exp_press=%b",
                             pass, k, kf_a.press_pulse[0], kf_a.key_level[0], (k == 13));
                end
                n_checks++;
                if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                    n_fail++;
                    $display("FAIL reset_model cyc=%0d got_a=%h got_b=%h exp_a=%h", cyc, obs_a, obs_b, exp_vec(1));
                end
            end
        end
        for (int k = 0; k < 20; k++) step('1);
    endtask

    task automatic test_multi_channel();
        step(4'b0110);
        for (int k = 1; k <= 20; k++) begin
            step(4'b0110);
            n_checks++;
            if (kf_a.press_pulse !== (k == 13 ? 4'b1001 : 4'b0000) ||
                kf_a.key_level[2:1] !== 2'b00) begin
                n_fail++;
                $display("FAIL multi_press k=%0d got_press=%b got_level=%b", k, kf_a.press_pulse, kf_a.key_level);
            end
            n_checks++;
            if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL multi_model cyc=%0d got_a=%h got_b=%h exp_a=%h", cyc, obs_a, obs_b, exp_vec(1));
            end
        end
        for (int k = 0; k < 20; k++) step('1);
    endtask

    task automatic test_random();
        int           rem [N];
        logic [N-1:0] pins;
        pins = '1;
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 30);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    pins[i] = ~pins[i];
                    rem[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : $urandom_range(5, 130);
                end
            end
            step(pins);
            n_checks++;
            if (obs_a !== exp_vec(1) || obs_b !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got_a=%h got_b=%h exp_a=%h exp_b=%h",
                         cyc, obs_a, obs_b, exp_vec(1), exp_vec(0));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        model_reset();
        #1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_glitch();
        test_reset_mid();
        test_multi_channel();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
